// File: rtl/io_uart_pkg.sv
// Shared constants and types for the IO-mapped UART transmitter.
package io_uart_pkg;

    localparam logic [1:0] TXDATA = 2'd0;
    localparam logic [1:0] STATUS = 2'd1;
    localparam logic [1:0] DIV    = 2'd2;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/io_uart_tx_if.sv
// Core-side IO bus as seen by the UART: address, store strobe/data, combinational read data.
interface io_uart_tx_if;
    logic [31:0] IO_mem_addr;
    logic [31:0] IO_mem_wdata;
    logic        IO_mem_wr;
    logic [31:0] IO_mem_rdata;

    modport master (output IO_mem_addr, output IO_mem_wdata, output IO_mem_wr, input IO_mem_rdata);
    modport slave  (input IO_mem_addr, input IO_mem_wdata, input IO_mem_wr, output IO_mem_rdata);
endinterface

// File: rtl/io_uart_tx_sync_fifo.sv
// Single-clock FIFO; a push while full is dropped, dout is read straight from the read pointer.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (push_ok_s && !pop_ok_s) begin
                count_r <= count_r + (AW+1)'(1);
            end else if (pop_ok_s && !push_ok_s) begin
                count_r <= count_r - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO and bit serialiser.
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    io_uart_tx_if.slave  bus,
    output logic         uart_tx,
    output logic         tx_irq
);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] DIV_RESET = 16'(CLK_FREQ / BAUD);

    tx_state_t     state_r;
    logic [7:0]    shift_r;
    logic [2:0]    bit_idx_r;
    logic [15:0]   bit_cnt_r;
    logic [15:0]   div_act_r;
    logic [15:0]   div_r;
    logic          overflow_r;

    logic [1:0]    reg_sel_s;
    logic          wr_txdata_s;
    logic          wr_status_s;
    logic          wr_div_s;
    logic          push_ok_s;
    logic          pop_s;
    logic [7:0]    fifo_dout_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [CW-1:0] count_next_s;
    logic          next_idle_s;
    logic [31:0]   rdata_s;
    logic          unused_s;

    assign reg_sel_s   = bus.IO_mem_addr[3:2];
    assign wr_txdata_s = bus.IO_mem_wr && (reg_sel_s == TXDATA);
    assign wr_status_s = bus.IO_mem_wr && (reg_sel_s == STATUS);
    assign wr_div_s    = bus.IO_mem_wr && (reg_sel_s == DIV);
    assign push_ok_s   = wr_txdata_s && !fifo_full_s;
    assign pop_s       = (state_r == IDLE) && !fifo_empty_s;
    assign unused_s    = ^{bus.IO_mem_addr[31:4], bus.IO_mem_addr[1:0], bus.IO_mem_wdata[31:16]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata_s),
        .pop   (pop_s),
        .din   (bus.IO_mem_wdata[7:0]),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Divisor register (zero is promoted to one) and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r      <= DIV_RESET;
            overflow_r <= 1'b0;
        end else begin
            if (wr_div_s) begin
                div_r <= (bus.IO_mem_wdata[15:0] == 16'd0) ? 16'd1 : bus.IO_mem_wdata[15:0];
            end
            if (wr_status_s) begin
                overflow_r <= 1'b0;
            end else if (wr_txdata_s && fifo_full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Next-cycle FIFO occupancy and FSM idleness, used to register tx_irq.
    always_comb begin
        count_next_s = fifo_count_s;
        next_idle_s  = 1'b0;
        if (push_ok_s && !pop_s) begin
            count_next_s = fifo_count_s + CW'(1);
        end else if (pop_s && !push_ok_s) begin
            count_next_s = fifo_count_s - CW'(1);
        end else begin
            count_next_s = fifo_count_s;
        end
        case (state_r)
            IDLE:    next_idle_s = fifo_empty_s;
            STOP:    next_idle_s = (bit_cnt_r == 16'd0);
            default: next_idle_s = 1'b0;
        endcase
    end

    // Serialiser FSM; uart_tx is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            shift_r   <= 8'd0;
            bit_idx_r <= 3'd0;
            bit_cnt_r <= 16'd0;
            div_act_r <= DIV_RESET;
            uart_tx   <= 1'b1;
            tx_irq    <= 1'b1;
        end else begin
            tx_irq <= next_idle_s && (count_next_s == CW'(0));
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        state_r   <= START;
                        shift_r   <= fifo_dout_s;
                        div_act_r <= div_r;
                        bit_cnt_r <= div_r - 16'd1;
                        uart_tx   <= 1'b0;
                    end else begin
                        uart_tx <= 1'b1;
                    end
                end
                START: begin
                    if (bit_cnt_r == 16'd0) begin
                        state_r   <= DATA;
                        bit_idx_r <= 3'd0;
                        bit_cnt_r <= div_act_r - 16'd1;
                        uart_tx   <= shift_r[0];
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_cnt_r == 16'd0) begin
                        bit_cnt_r <= div_act_r - 16'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            shift_r   <= {1'b0, shift_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                            uart_tx   <= shift_r[1];
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_cnt_r == 16'd0) begin
                        state_r <= IDLE;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

    // Combinational read mux; reads have no side effects.
    always_comb begin
        rdata_s = 32'd0;
        case (reg_sel_s)
            STATUS: begin
                rdata_s[ST_BUSY]                    = (state_r != IDLE);
                rdata_s[ST_FULL]                    = fifo_full_s;
                rdata_s[ST_EMPTY]                   = fifo_empty_s;
                rdata_s[ST_OVERFLOW]                = overflow_r;
                rdata_s[ST_COUNT_LSB+7:ST_COUNT_LSB] = 8'(fifo_count_s);
            end
            DIV:     rdata_s = {16'd0, div_r};
            default: rdata_s = 32'd0;
        endcase
    end

    assign bus.IO_mem_rdata = rdata_s;

endmodule

// File: tb/tb_io_uart_tx.sv
// Scoreboard bench: queued bytes are checked against frames decoded cycle-by-cycle from uart_tx.
module tb_io_uart_tx;
    import io_uart_pkg::*;

    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD      = 115_200;
    localparam int DEPTH     = 16;
    localparam int DIV_RST   = CLK_FREQ / BAUD;
    localparam logic [31:0] A_TX  = 32'h0000_0000;
    localparam logic [31:0] A_ST  = 32'h0000_0004;
    localparam logic [31:0] A_DIV = 32'h0000_0008;
    localparam logic [31:0] A_RSV = 32'h0000_000C;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_tx;
    logic tx_irq;

    io_uart_tx_if bus();

    io_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .uart_tx (uart_tx),
        .tx_irq  (tx_irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int m_div = DIV_RST;
    int last_wr_cyc = 0;
    int frames_done = 0;
    logic [7:0] exp_q[$];
    int start_q[$];
    bit mon_active = 1'b0;
    bit abort_req = 1'b0;
    bit check_lat = 1'b0;
    int mon_pos, mon_div, mon_bad, bit_n;
    logic [7:0] mon_byte, mon_obs;
    logic lvl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Frame monitor: checks every cycle of a frame against the expected waveform.
    always @(negedge clk) begin
        if (abort_req) begin
            mon_active = 1'b0;
            abort_req  = 1'b0;
        end else if (!reset) begin
            if (!mon_active && uart_tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_frame", 32'd1, 32'd0);
                    mon_byte = 8'h00;
                end else begin
                    mon_byte = exp_q.pop_front();
                end
                mon_div = m_div;
                mon_pos = 0;
                mon_bad = 0;
                mon_obs = 8'h00;
                mon_active = 1'b1;
                start_q.push_back(cyc);
                if (check_lat) begin
                    chk("start_latency", cyc - last_wr_cyc, 32'd1);
                    check_lat = 1'b0;
                end
            end
            if (mon_active) begin
                bit_n = mon_pos / mon_div;
                lvl = (bit_n == 0) ? 1'b0 : (bit_n == 9) ? 1'b1 : mon_byte[bit_n-1];
                if (uart_tx !== lvl) mon_bad++;
                if (bit_n >= 1 && bit_n <= 8 && (mon_pos % mon_div) == (mon_div / 2))
                    mon_obs[bit_n-1] = uart_tx;
                mon_pos++;
                if (mon_pos == 10 * mon_div) begin
                    chk("frame_data", mon_obs, mon_byte);
                    chk("frame_shape_errs", mon_bad, 32'd0);
                    mon_active = 1'b0;
                    frames_done++;
                end
            end
        end
    end

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.IO_mem_addr  = a;
        bus.IO_mem_wdata = d;
        bus.IO_mem_wr    = 1'b1;
        @(posedge clk);
        #1;
        bus.IO_mem_wr = 1'b0;
        last_wr_cyc   = cyc;
        if (a[3:2] == 2'd2 && !reset) m_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.IO_mem_addr = a;
        bus.IO_mem_wr   = 1'b0;
        #1 d = bus.IO_mem_rdata;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active || tx_irq !== 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_budget", (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int s0, peak, f0;
        bus.IO_mem_addr  = 32'd0;
        bus.IO_mem_wdata = 32'd0;
        bus.IO_mem_wr    = 1'b0;

        // Reset defaults, with a store attempted while reset is held.
        bus_wr(A_TX, 32'h55);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        bus_rd(A_ST, rd);   chk("reset_status", rd, 32'h4);
        bus_rd(A_DIV, rd);  chk("reset_div", rd, DIV_RST);
        chk("reset_uart_tx", uart_tx, 32'd1);
        chk("reset_tx_irq", tx_irq, 32'd1);
        bus_rd(A_TX, rd);   chk("txdata_read_zero", rd, 32'd0);
        bus_rd(A_RSV, rd);  chk("reserved_read_zero", rd, 32'd0);
        bus_wr(A_RSV, 32'hFFFF);
        bus_rd(A_DIV, rd);  chk("reserved_write_ignored", rd, DIV_RST);

        // DIV=0 stored as 1; one-cycle bits.
        bus_wr(A_DIV, 32'd0);
        bus_rd(A_DIV, rd);  chk("div_zero_as_one", rd, 32'd1);
        exp_q.push_back(8'h3C);
        bus_wr(A_TX, 32'h3C);
        wait_done(100);

        // Single frame at DIV=4.
        bus_wr(A_DIV, 32'd4);
        exp_q.push_back(8'hA5);
        check_lat = 1'b1;
        bus_wr(A_TX, 32'hA5);
        chk("irq_falls_after_push", tx_irq, 32'd0);
        bus_rd(A_ST, rd);   chk("status_after_push", rd & 32'h4, 32'h0);
        wait_done(200);
        chk("irq_back_high", tx_irq, 32'd1);
        chk("latency_checked", check_lat, 32'd0);

        // Back-to-back at DIV=2.
        bus_wr(A_DIV, 32'd2);
        s0 = start_q.size();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        bus_wr(A_TX, 32'h00);
        bus_wr(A_TX, 32'hFF);
        peak = 0;
        for (int i = 0; i < 50; i++) begin
            bus_rd(A_ST, rd);
            if (int'(rd[15:8]) > peak) peak = int'(rd[15:8]);
        end
        chk("b2b_count_peak", peak, 32'd1);
        wait_done(200);
        chk("b2b_frames", start_q.size() - s0, 32'd2);
        if (start_q.size() >= s0 + 2) chk("b2b_gap", start_q[s0+1] - start_q[s0], 32'd21);

        // DIV change during bit 2 only affects the following frame.
        bus_wr(A_DIV, 32'd3);
        s0 = start_q.size();
        exp_q.push_back(8'h96);
        bus_wr(A_TX, 32'h96);
        repeat (10) @(posedge clk);
        bus_wr(A_DIV, 32'd5);
        exp_q.push_back(8'h4B);
        bus_wr(A_TX, 32'h4B);
        bus_rd(A_DIV, rd);  chk("div_readback_5", rd, 32'd5);
        wait_done(300);
        if (start_q.size() >= s0 + 2) chk("midframe_gap", start_q[s0+1] - start_q[s0], 32'd31);
        else chk("midframe_frames", start_q.size() - s0, 32'd2);

        // Overflow: one byte in the serialiser, DEPTH queued, last one dropped.
        bus_wr(A_DIV, 32'd100);
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i < DEPTH + 1) exp_q.push_back(8'(8'h30 + i));
            bus_wr(A_TX, 32'h30 + i);
        end
        bus_rd(A_ST, rd);   chk("overflow_status", rd, 32'h0000_100B);
        bus_wr(A_ST, 32'd0);
        bus_rd(A_ST, rd);   chk("overflow_cleared", rd, 32'h0000_1003);
        wait_done(20000);
        repeat (50) @(posedge clk);
        bus_rd(A_ST, rd);   chk("overflow_drained", rd, 32'h4);

        // Reset during DATA with bytes queued.
        bus_wr(A_DIV, 32'd3);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'(8'hC1 + i));
            bus_wr(A_TX, 32'hC1 + i);
        end
        repeat (9) @(posedge clk);
        @(negedge clk);
        abort_req = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        m_div = DIV_RST;
        chk("abort_uart_tx", uart_tx, 32'd1);
        bus_rd(A_ST, rd);   chk("abort_status", rd, 32'h4);
        f0 = frames_done;
        repeat (300) @(posedge clk);
        chk("abort_no_frames", frames_done - f0, 32'd0);
        chk("abort_line_idle", uart_tx, 32'd1);
        chk("abort_irq", tx_irq, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped UART transmitter on the core's IO port, downstream of the memory stage. Stores to its registers push bytes into a transmit FIFO. A bit-serialiser drains the FIFO onto the `uart_tx` pin as 8N1 frames. The status register is readable through the core's combinational IO read path.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115_200: reset baud rate. Reset divisor is `CLK_FREQ/BAUD` (integer division).
- `FIFO_DEPTH`, 16: transmit FIFO entries. Must be a power of two, ≥2.

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `IO_mem_addr` in 32: IO byte address from the core. Register select is bits [3:2]; other bits are ignored, because the top level decodes the region.
- `IO_mem_wdata` in 32: store data.
- `IO_mem_wr` in 1: one-cycle store strobe, already qualified by the IO region.
- `IO_mem_rdata` out 32: read data, a combinational function of `IO_mem_addr` and current state.
- `uart_tx` out 1: serial output, idle high.
- `tx_irq` out 1: registered; high while the FIFO is empty and the serialiser is idle.

## Operation
Register map, selected by `IO_mem_addr[3:2]`:
- 0 `TXDATA`:
  - Write pushes `IO_mem_wdata[7:0]`.
  - Read returns 0.
- 1 `STATUS`, read:
  - bit0 `busy` (serialiser not idle)
  - bit1 `full`
  - bit2 `empty`
  - bit3 `overflow` (sticky)
  - bits[15:8] FIFO count, zero-extended
  - all other bits 0
- 1 `STATUS`, write: any write clears `overflow`.
- 2 `DIV`:
  - Read/write, 16 bits, in cycles per bit. Upper bits of the read are 0.
  - A write of 0 is stored as 1.
- 3: reserved. Reads return 0; writes are ignored.

Push behaviour:
- A `TXDATA` write with the FIFO not full pushes the byte.
- A `TXDATA` write with the FIFO full drops the byte and sets `overflow`.
- A push in the same cycle as a pop when full is still an overflow: full is evaluated before the pop.

Serialiser FSM states:
- `IDLE`:
  - `uart_tx`=1.
  - If the FIFO is not empty, pop into the 8-bit shift register, load the active divisor from `DIV`, and go to `START`.
- `START`: drive 0 for `div` cycles, then go to `DATA` with bit index 0.
- `DATA`:
  - Drive `shift[0]` for `div` cycles, then shift right and increment the index.
  - After index 7 completes, go to `STOP`.
- `STOP`: drive 1 for `div` cycles, then go to `IDLE`.

Divisor and bit-counter rules:
- The divisor is latched per frame. A `DIV` write mid-frame affects only the next frame.
- The bit-time counter counts down from `div-1` to 0.
- The bit index is 3 bits.
- The FIFO count is `$clog2(FIFO_DEPTH)+1` bits.
- Pointers wrap modulo `FIFO_DEPTH`.

## Timing
Reset values:
- `uart_tx`=1
- `tx_irq`=1
- FSM `IDLE`
- FIFO empty, pointers 0
- `overflow`=0
- `DIV`=`CLK_FREQ/BAUD`
- `IO_mem_rdata` reflects these values in the same cycle.

Latency and frame length:
- A `TXDATA` write at edge N makes the entry visible at N+1 (`empty`=0, count incremented).
- If the FSM is idle, the pop happens at edge N+1 and `uart_tx` falls after edge N+1. The start bit therefore begins 1 cycle after the write is registered.
- A frame lasts exactly `10*div` cycles.
- Back-to-back frames have exactly 1 `IDLE` cycle between the stop bit and the next start bit.

Boundary conditions:
- **Simultaneous push and pop:** both occur and the count is unchanged.
- **Push into an empty FIFO:** not bypassed; the 1-cycle latency above applies.
- **`tx_irq`:** registered from next-state values. It falls the cycle after the first push.
- **`DIV`=1:** each bit lasts 1 cycle.
- **Reset mid-frame:** the frame is aborted, `uart_tx`=1 after the edge, and the FIFO is flushed.
- **Writes during reset:** ignored.
- **Read side effects:** reads have none.

## Structure
- The package `io_uart_pkg` holds:
  - register index constants: `TXDATA`=0, `STATUS`=1, `DIV`=2
  - STATUS bit positions
  - the FSM state enum: `IDLE`, `START`, `DATA`, `STOP`
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`):
  - ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`
  - `dout` is valid combinationally from the read pointer
  - reusable by a future UART RX.
- The top level holds:
  - register decode
  - the `DIV` and `overflow` registers
  - the serialiser FSM
  - the read mux

## Test plan
- **Reset defaults:** after reset, read `STATUS` and `DIV`. Required: `STATUS`=0x00000004, `DIV`=`CLK_FREQ/BAUD`, `uart_tx`=1, `tx_irq`=1.
- **Single frame:** write `DIV`=4, then write `TXDATA`=0xA5. Required: `uart_tx` sequence 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles; start bit begins 1 cycle after the write is registered; total 40 cycles; `tx_irq` returns to 1.
- **Back-to-back:** with `DIV`=2, write 0x00 then 0xFF on consecutive cycles. Required: two 20-cycle frames with exactly 1 idle cycle between them; count peaks at 1.
- **Overflow:** with `DIV`=100, write `FIFO_DEPTH`+2 bytes. Required: `full`=1, `overflow`=1, count=`FIFO_DEPTH`; a `STATUS` write clears `overflow`; the dropped bytes are never transmitted.
- **Mid-frame DIV change:** with `DIV`=3, start a frame, then write `DIV`=5 during bit 2. Required: the current frame stays at 3 cycles/bit; the next frame runs at 5 cycles/bit.
- **Reset mid-frame:** assert `reset` for 1 cycle during `DATA` with 3 bytes queued. Required: `uart_tx`=1 and `STATUS`=0x4 after the edge, and no further frames are sent.
